// File: rtl/coin_pkg.sv
// Shared types and constants for the coin lane scheduler.
//   game_state_t : top-level game FSM states
//   lane_state_t : per-lane coin FSM states
//   LANE_NONE    : player lane code meaning "not in any lane"
//   LFSR_TAPS    : feedback mask for the 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1)
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAME_OVER
  } game_state_t;

  typedef enum logic [1:0] {
    L_IDLE,
    L_FLY,
    L_READY,
    L_COOL
  } lane_state_t;

  localparam logic [1:0] LANE_NONE = 2'd3;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // One LFSR step: shift left, XOR of the tapped bits enters at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/coin_lane_fsm.sv
// Per-lane coin controller: spawns, waits for the sprite to arrive, then
// scores a collect or a miss and cools down before the lane can respawn.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   spawn        : start a coin in this lane (only honoured in L_IDLE)
//   eval         : decision strobe, a fixed delay after each frame tick
//   tick         : frame tick, times the cool-down
//   in_position  : sprite has reached its collect position
//   lane_match   : player is standing in this lane
//   force_cool   : hold the lane in L_COOL (game over)
//   active       : registered sprite enable
//   collect_c    : combinational collect on this eval
//   miss_c       : combinational miss on this eval
//   is_idle_c    : lane can accept a spawn
module coin_lane_fsm
  import coin_pkg::*;
#(
  parameter int unsigned MISS_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic spawn,
  input  logic eval,
  input  logic tick,
  input  logic in_position,
  input  logic lane_match,
  input  logic force_cool,
  output logic active,
  output logic collect_c,
  output logic miss_c,
  output logic is_idle_c
);

  localparam int unsigned MISS_W = $clog2(MISS_FRAMES + 1);

  lane_state_t       state;
  logic [MISS_W-1:0] miss_cnt;
  logic              cool_cnt;
  logic              ready_eval_c;

  assign ready_eval_c = (state == L_READY) && eval;
  assign collect_c    = ready_eval_c && lane_match;
  // The eval that would bring the count up to MISS_FRAMES is the miss.
  assign miss_c       = ready_eval_c && !lane_match && (miss_cnt == MISS_W'(MISS_FRAMES - 1));
  assign is_idle_c    = (state == L_IDLE);

  // Lane state machine; active tracks the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= L_IDLE;
      miss_cnt <= '0;
      cool_cnt <= 1'b0;
      active   <= 1'b0;
    end else if (force_cool) begin
      state    <= L_COOL;
      cool_cnt <= 1'b0;
      active   <= 1'b0;
    end else begin
      case (state)
        L_IDLE: begin
          if (spawn) begin
            state    <= L_FLY;
            miss_cnt <= '0;
            active   <= 1'b1;
          end
        end
        L_FLY: begin
          if (eval && in_position) state <= L_READY;
        end
        L_READY: begin
          if (eval) begin
            if (lane_match || miss_c) begin
              state    <= L_COOL;
              cool_cnt <= 1'b0;
              active   <= 1'b0;
            end else begin
              miss_cnt <= miss_cnt + MISS_W'(1);
            end
          end
        end
        L_COOL: begin
          // Two ticks with active low so the sprite reloads its start position.
          if (tick) begin
            if (cool_cnt) state <= L_IDLE;
            else          cool_cnt <= 1'b1;
          end
        end
        default: state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/coin_lane_scheduler.sv
// Game-level coin scheduler: frame tick/eval generation, LFSR lane choice,
// spawn timer, score/lives bookkeeping and the game state machine.
// Ports:
//   i_clk, i_rst   : pixel clock, synchronous active-high reset
//   i_v_sync       : vsync level (i_clk domain); rising edge is the frame tick
//   i_start        : start from IDLE / restart from GAME_OVER
//   i_player_lane  : player lane 0..2, 3 = none
//   i_in_position  : per-lane sprite arrival flags
//   o_coin_active  : per-lane sprite enables
//   o_score        : collected coins (saturating)
//   o_lives        : remaining lives
//   o_collect      : pulse on any collect
//   o_miss         : pulse on any miss
//   o_game_over    : high in GAME_OVER
module coin_lane_scheduler
  import coin_pkg::*;
#(
  parameter int unsigned N_LANES      = 3,
  parameter int unsigned SPAWN_FRAMES = 45,
  parameter int unsigned MISS_FRAMES  = 8,
  parameter int unsigned START_LIVES  = 3,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5,
  parameter int unsigned SCORE_W      = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_v_sync,
  input  logic               i_start,
  input  logic [1:0]         i_player_lane,
  input  logic [N_LANES-1:0] i_in_position,
  output logic [N_LANES-1:0] o_coin_active,
  output logic [SCORE_W-1:0] o_score,
  output logic [3:0]         o_lives,
  output logic               o_collect,
  output logic               o_miss,
  output logic               o_game_over
);

  localparam int unsigned SPAWN_W = $clog2(SPAWN_FRAMES);
  localparam int unsigned CNT_W   = $clog2(N_LANES + 1);
  localparam int unsigned SUM_W   = SCORE_W + CNT_W;

  logic               vs_q;
  logic               tick_d1;
  logic               eval_q;
  logic               tick_c;
  logic [7:0]         lfsr;
  game_state_t        game_state;
  logic [SPAWN_W-1:0] spawn_cnt;
  logic               spawn_try_c;
  logic               force_cool_c;
  logic [1:0]         cand_c;
  logic [N_LANES-1:0] spawn_c;
  logic [N_LANES-1:0] lane_idle_c;
  logic [N_LANES-1:0] lane_collect_c;
  logic [N_LANES-1:0] lane_miss_c;
  logic [N_LANES-1:0] lane_active;
  logic [CNT_W-1:0]   n_collect_c;
  logic [CNT_W-1:0]   n_miss_c;
  logic [SUM_W-1:0]   score_sum_c;
  logic [SCORE_W-1:0] score_next_c;
  logic [3:0]         lives_next_c;

  assign tick_c        = i_v_sync & ~vs_q;
  assign spawn_try_c   = (game_state == RUN) && tick_c &&
                         (spawn_cnt == SPAWN_W'(SPAWN_FRAMES - 1));
  assign force_cool_c  = (game_state == GAME_OVER);
  assign o_coin_active = lane_active;

  // Candidate lane from the LFSR; codes beyond the last lane fold to lane 0.
  assign cand_c = (32'(lfsr[1:0]) >= N_LANES) ? 2'd0 : lfsr[1:0];

  // First idle lane searching forward cyclically from the candidate.
  always_comb begin
    logic found;
    spawn_c = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      for (int unsigned j = 0; j < N_LANES; j++) begin
        if (!found && lane_idle_c[j] && (j == (32'(cand_c) + k) % N_LANES)) begin
          spawn_c[j] = spawn_try_c;
          found      = 1'b1;
        end
      end
    end
  end

  // Collect/miss counts and saturating score/lives updates.
  always_comb begin
    n_collect_c = '0;
    n_miss_c    = '0;
    for (int unsigned j = 0; j < N_LANES; j++) begin
      n_collect_c = n_collect_c + CNT_W'(lane_collect_c[j]);
      n_miss_c    = n_miss_c + CNT_W'(lane_miss_c[j]);
    end
    score_sum_c  = SUM_W'(o_score) + SUM_W'(n_collect_c);
    score_next_c = (|score_sum_c[SUM_W-1:SCORE_W]) ? '1 : score_sum_c[SCORE_W-1:0];
    lives_next_c = (4'(n_miss_c) >= o_lives) ? 4'd0 : o_lives - 4'(n_miss_c);
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    coin_lane_fsm #(
      .MISS_FRAMES(MISS_FRAMES)
    ) u_lane (
      .clk        (i_clk),
      .rst        (i_rst),
      .spawn      (spawn_c[g]),
      .eval       (eval_q),
      .tick       (tick_c),
      .in_position(i_in_position[g]),
      .lane_match ((i_player_lane != LANE_NONE) && (i_player_lane == 2'(g))),
      .force_cool (force_cool_c),
      .active     (lane_active[g]),
      .collect_c  (lane_collect_c[g]),
      .miss_c     (lane_miss_c[g]),
      .is_idle_c  (lane_idle_c[g])
    );
  end

  // Tick/eval pipeline, LFSR, spawn timer, score/lives and game FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_q        <= 1'b0;
      tick_d1     <= 1'b0;
      eval_q      <= 1'b0;
      lfsr        <= LFSR_SEED;
      game_state  <= IDLE;
      spawn_cnt   <= '0;
      o_score     <= '0;
      o_lives     <= 4'(START_LIVES);
      o_collect   <= 1'b0;
      o_miss      <= 1'b0;
      o_game_over <= 1'b0;
    end else begin
      vs_q      <= i_v_sync;
      tick_d1   <= tick_c;
      eval_q    <= tick_d1;
      o_collect <= |lane_collect_c;
      o_miss    <= |lane_miss_c;
      if (tick_c) lfsr <= lfsr_next(lfsr);
      case (game_state)
        IDLE: begin
          if (i_start) begin
            game_state <= RUN;
            o_score    <= '0;
            o_lives    <= 4'(START_LIVES);
            spawn_cnt  <= '0;
          end
        end
        RUN: begin
          o_score <= score_next_c;
          o_lives <= lives_next_c;
          if (tick_c) spawn_cnt <= spawn_try_c ? '0 : spawn_cnt + SPAWN_W'(1);
          if (o_lives == 4'd0) begin
            game_state  <= GAME_OVER;
            o_game_over <= 1'b1;
          end
        end
        GAME_OVER: begin
          if (i_start) begin
            game_state  <= RUN;
            o_game_over <= 1'b0;
            o_score     <= '0;
            o_lives     <= 4'(START_LIVES);
            spawn_cnt   <= '0;
          end
        end
        default: game_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_lane_scheduler.sv
// Self-checking bench for coin_lane_scheduler: a frame-level reference model
// predicts lane states, score and lives; collect/miss events are queued when a
// frame is driven and popped when the DUT pulses.
module tb_coin_lane_scheduler;

  localparam int N_LANES      = 3;
  localparam int SPAWN_FRAMES = 45;
  localparam int MISS_FRAMES  = 8;
  localparam int START_LIVES  = 3;
  localparam int SCORE_W      = 10;
  localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               v_sync;
  logic               start;
  logic [1:0]         player_lane;
  logic [N_LANES-1:0] in_position;
  logic [N_LANES-1:0] coin_active;
  logic [SCORE_W-1:0] score;
  logic [3:0]         lives;
  logic               collect;
  logic               miss;
  logic               game_over;

  always #5 clk = ~clk;

  coin_lane_scheduler dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_v_sync     (v_sync),
    .i_start      (start),
    .i_player_lane(player_lane),
    .i_in_position(in_position),
    .o_coin_active(coin_active),
    .o_score      (score),
    .o_lives      (lives),
    .o_collect    (collect),
    .o_miss       (miss),
    .o_game_over  (game_over)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        collect;
    logic        miss;
    logic [31:0] score;
    logic [31:0] lives;
  } ev_t;
  ev_t exp_q[$];

  // Reference model state (lane: 0 idle, 1 fly, 2 ready, 3 cool; game: 0 idle, 1 run, 2 over).
  int         m_lane[N_LANES];
  int         m_miss[N_LANES];
  int         m_cool[N_LANES];
  int         m_cnt;
  int         m_score;
  int         m_lives;
  int         m_game;
  logic [7:0] m_lfsr;

  task automatic model_reset();
    for (int l = 0; l < N_LANES; l++) begin
      m_lane[l] = 0;
      m_miss[l] = 0;
      m_cool[l] = 0;
    end
    m_cnt   = 0;
    m_score = 0;
    m_lives = START_LIVES;
    m_game  = 0;
    m_lfsr  = 8'hA5;
  endtask

  function automatic logic [N_LANES-1:0] model_active();
    logic [N_LANES-1:0] a;
    a = '0;
    for (int l = 0; l < N_LANES; l++) a[l] = (m_lane[l] == 1) || (m_lane[l] == 2);
    return a;
  endfunction

  // One frame: the tick (spawn, cool-down, LFSR step) then the eval.
  task automatic model_frame(input logic [N_LANES-1:0] inpos, input logic [1:0] plane);
    int  spawn_lane;
    int  cand;
    int  nc;
    int  nm;
    bit  found;
    ev_t ev;
    spawn_lane = -1;
    if (m_game == 1) begin
      if (m_cnt == SPAWN_FRAMES - 1) begin
        m_cnt = 0;
        cand  = int'(m_lfsr[1:0]);
        if (cand >= N_LANES) cand = 0;
        found = 1'b0;
        for (int k = 0; k < N_LANES; k++) begin
          if (!found && m_lane[(cand + k) % N_LANES] == 0) begin
            spawn_lane = (cand + k) % N_LANES;
            found      = 1'b1;
          end
        end
      end else begin
        m_cnt++;
      end
    end
    for (int l = 0; l < N_LANES; l++) begin
      if (m_lane[l] == 3 && m_game != 2) begin
        if (m_cool[l] == 1) m_lane[l] = 0;
        else                m_cool[l] = 1;
      end
    end
    if (spawn_lane >= 0) begin
      m_lane[spawn_lane] = 1;
      m_miss[spawn_lane] = 0;
    end
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    nc = 0;
    nm = 0;
    for (int l = 0; l < N_LANES; l++) begin
      if (m_lane[l] == 1) begin
        if (inpos[l]) m_lane[l] = 2;
      end else if (m_lane[l] == 2) begin
        if (int'(plane) == l) begin
          nc++;
          m_lane[l] = 3;
          m_cool[l] = 0;
        end else begin
          m_miss[l]++;
          if (m_miss[l] == MISS_FRAMES) begin
            nm++;
            m_lane[l] = 3;
            m_cool[l] = 0;
          end
        end
      end
    end
    m_score = (m_score + nc > SCORE_MAX) ? SCORE_MAX : m_score + nc;
    m_lives = (nm >= m_lives) ? 0 : m_lives - nm;
    if (nc > 0 || nm > 0) begin
      ev.collect = (nc > 0);
      ev.miss    = (nm > 0);
      ev.score   = m_score;
      ev.lives   = m_lives;
      exp_q.push_back(ev);
    end
    if (m_game == 1 && m_lives == 0) begin
      m_game = 2;
      for (int l = 0; l < N_LANES; l++) begin
        m_lane[l] = 3;
        m_cool[l] = 0;
      end
    end
  endtask

  // Every collect/miss pulse must match the next queued event.
  always @(negedge clk) begin
    if (collect || miss) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_pulse", {30'd0, collect, miss}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check_val("ev_collect", collect, e.collect);
        check_val("ev_miss", miss, e.miss);
        check_val("ev_score", score, e.score);
        check_val("ev_lives", lives, e.lives);
      end
    end
  end

  // Drive one vsync frame (called at a falling edge) and compare against the model.
  task automatic run_frame(input logic [N_LANES-1:0] inpos, input logic [1:0] plane);
    in_position = inpos;
    player_lane = plane;
    model_frame(inpos, plane);
    v_sync = 1'b1;
    repeat (5) @(negedge clk);
    v_sync = 1'b0;
    repeat (3) @(negedge clk);
    check_val("active", coin_active, model_active());
    check_val("score", score, m_score);
    check_val("lives", lives, m_lives);
    check_val("game_over", game_over, (m_game == 2));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (m_game != 1) begin
      m_game  = 1;
      m_score = 0;
      m_lives = START_LIVES;
      m_cnt   = 0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_active"}, coin_active, 0);
    check_val({tag, "_score"}, score, 0);
    check_val({tag, "_lives"}, lives, START_LIVES);
    check_val({tag, "_collect"}, collect, 0);
    check_val({tag, "_miss"}, miss, 0);
    check_val({tag, "_game_over"}, game_over, 0);
  endtask

  function automatic int first_busy_lane();
    for (int l = 0; l < N_LANES; l++)
      if (m_lane[l] == 1 || m_lane[l] == 2) return l;
    return -1;
  endfunction

  initial begin
    int l0;
    rst         = 1'b1;
    v_sync      = 1'b0;
    start       = 1'b0;
    player_lane = 2'd3;
    in_position = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // IDLE frames still advance the LFSR but never spawn.
    repeat (3) run_frame('0, 2'd3);

    // First spawn after SPAWN_FRAMES ticks, lane chosen from the LFSR.
    do_start();
    repeat (SPAWN_FRAMES) run_frame('0, 2'd3);
    check_val("first_spawn_onehot", $countones(coin_active), 1);

    // Collect: arrive, then the player steps into the lane.
    l0 = first_busy_lane();
    if (l0 < 0) l0 = 0;
    run_frame(3'(1 << l0), 2'd3);
    run_frame(3'(1 << l0), 2'(l0));
    run_frame('0, 2'd3);
    run_frame('0, 2'd3);

    // i_start is ignored while running.
    do_start();
    run_frame('0, 2'd3);
    check_val("start_ignored_score", score, m_score);

    // Misses until game over; first with a wrong lane, later with no lane.
    for (int i = 0; i < 600 && m_game != 2; i++) begin
      int b;
      b = first_busy_lane();
      if (b < 0) run_frame('0, 2'd3);
      else if (m_lives == START_LIVES) run_frame(3'(1 << b), 2'((b + 1) % N_LANES));
      else run_frame(3'(1 << b), 2'd3);
    end
    check_val("game_over_reached", game_over, 1);
    repeat (2) run_frame('1, 2'd3);

    // Restart clears score and lives.
    do_start();
    run_frame('0, 2'd3);
    check_val("restart_score", score, 0);
    check_val("restart_lives", lives, START_LIVES);

    // Fill all lanes, then a further period finds no idle lane.
    repeat (4 * SPAWN_FRAMES + 2) run_frame('0, 2'd3);
    check_val("all_fly", coin_active, 3'b111);

    // Lane 2 reaches the miss limit on the same eval lane 0 is collected.
    run_frame(3'b100, 2'd3);
    repeat (MISS_FRAMES - 2) run_frame(3'b100, 2'd3);
    run_frame(3'b101, 2'd3);
    run_frame(3'b101, 2'd0);
    run_frame('0, 2'd3);

    // Synchronous reset mid-run with a coin still flying.
    check_val("sb_empty_before_reset", exp_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrun_reset");
    rst = 1'b0;
    model_reset();
    repeat (2) run_frame('0, 2'd3);

    // After reset the LFSR restarts from its seed.
    do_start();
    repeat (SPAWN_FRAMES) run_frame('0, 2'd3);
    check_val("respawn_onehot", $countones(coin_active), 1);

    check_val("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
